// File: rtl/plot_grid_sink.sv
// plot_grid_sink
// Shadows the pixel stream a drawer sends to the VGA adapter and keeps a
// 10 x 20 board of cells. Each cell holds an occupancy bit and, optionally,
// the 6-bit colour last plotted into it. The board can be queried cell by
// cell and scanned row by row for completely filled rows.
//
// Build option: define PLOT_GRID_COLOUR_STORE_EN to keep per-cell colour.
// Without it, no colour storage is built and r_colour is tied to zero.
//
// Ports
//   clock, resetn             system clock, async active-low reset
//   x, y, colour, plot        pixel write bus (colour 0 = background)
//   clear_all                 empty the whole board in one cycle
//   q_valid, q_col, q_row     cell query request
//   r_valid, r_occupied,
//   r_colour                  query response, one cycle after the request
//   scan_start, scan_busy,
//   scan_done, full_rows      full-row scan control and result
//   oob_count                 saturating count of plots outside the board
//
// Scan FSM
//   state | meaning
//   IDLE  | waiting for scan_start
//   SCAN  | examining row row_idx (0..19), one row per cycle
//   DONE  | full_rows updated, scan_done high for this cycle
module plot_grid_sink #(
   parameter logic [7:0] ORIGIN_X   = 8'd16,
   parameter logic [6:0] ORIGIN_Y   = 7'd8,
   parameter int         CELL_SHIFT = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [5:0]  colour,
   input  logic        plot,
   input  logic        clear_all,
   input  logic        q_valid,
   input  logic [3:0]  q_col,
   input  logic [4:0]  q_row,
   output logic        r_valid,
   output logic        r_occupied,
   output logic [5:0]  r_colour,
   input  logic        scan_start,
   output logic        scan_busy,
   output logic        scan_done,
   output logic [19:0] full_rows,
   output logic [7:0]  oob_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  dx;
   logic [7:0]  col_raw;
   logic [6:0]  dy;
   logic [6:0]  row_raw;
   logic        in_board;
   logic        wr_en;
   logic [3:0]  cell_col;
   logic [4:0]  cell_row;
   logic        q_in;

   logic [9:0]  occ [20];

   logic [4:0]  row_idx;
   logic [18:0] row_acc;
   logic        row_full;
   logic        last_row;

   // Pixel to cell mapping. The subtraction wraps for pixels left of or
   // above the origin, so the explicit >= compares are what reject them.
   assign dx       = x - ORIGIN_X;
   assign dy       = y - ORIGIN_Y;
   assign col_raw  = dx >> CELL_SHIFT;
   assign row_raw  = dy >> CELL_SHIFT;
   assign in_board = (x >= ORIGIN_X) && (y >= ORIGIN_Y) &&
                     (col_raw < 8'd10) && (row_raw < 7'd20);
   assign cell_col = col_raw[3:0];
   assign cell_row = row_raw[4:0];
   assign wr_en    = plot && in_board && !clear_all;

   assign q_in     = (q_col <= 4'd9) && (q_row <= 5'd19);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < 20; r++) occ[r] <= '0;
      end else if (clear_all) begin
         for (int r = 0; r < 20; r++) occ[r] <= '0;
      end else if (wr_en) begin
         occ[cell_row][cell_col] <= (colour != 6'd0);
      end
   end

   // Query reads the array before this edge's write lands, so a same-cycle
   // plot to the queried cell returns the old contents. Off-board cells
   // answer as solid walls.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_valid    <= 1'b0;
         r_occupied <= 1'b0;
      end else begin
         r_valid <= q_valid;
         if (q_valid) r_occupied <= q_in ? occ[q_row][q_col] : 1'b1;
      end
   end

`ifdef PLOT_GRID_COLOUR_STORE_EN
   logic [5:0] cmem [20][10];
   logic [5:0] r_colour_q;

   // Background plots store colour 0, which doubles as the cleared value.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) cmem[r][c] <= '0;
      end else if (clear_all) begin
         for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) cmem[r][c] <= '0;
      end else if (wr_en) begin
         cmem[cell_row][cell_col] <= colour;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)      r_colour_q <= '0;
      else if (q_valid) r_colour_q <= q_in ? cmem[q_row][q_col] : 6'd0;
   end

   assign r_colour = r_colour_q;
`else
   assign r_colour = 6'd0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         oob_count <= '0;
      else if (plot && !in_board && (oob_count != 8'hFF))
         oob_count <= oob_count + 8'd1;
   end

   assign row_full = &occ[row_idx];
   assign last_row = (row_idx == 5'd19);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (scan_start) state_nxt = SCAN;
         SCAN:    if (last_row)   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      scan_busy = (state != IDLE);
      scan_done = (state == DONE);
   end

   // Row results shift in from the top; after rows 0..18 have gone in,
   // row 0 sits at bit 0, so row 19 completes the word directly.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         row_idx   <= '0;
         row_acc   <= '0;
         full_rows <= '0;
      end else if (state == SCAN) begin
         row_idx <= row_idx + 5'd1;
         row_acc <= {row_full, row_acc[18:1]};
         if (last_row) full_rows <= {row_full, row_acc};
      end else begin
         row_idx <= '0;
      end
   end

endmodule

// File: doc/plot_grid_sink.md
PLOT_GRID_SINK -- requirements
Module: plot_grid_sink

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 8'd16, pixel x of board column 0 left edge.
REQ-002 SHALL have parameter ORIGIN_Y, default 7'd8, pixel y of board row 0 top edge.
REQ-003 SHALL have parameter CELL_SHIFT, default 2, log2 of cell size in pixels (4x4 cells).
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 x  in  8  plotted pixel column, same bus the drawer drives into the VGA adapter.
REQ-007 y  in  7  plotted pixel row.
REQ-008 colour  in  6  plotted colour; 6'd0 means background.
REQ-009 plot  in  1  pixel write strobe, one pixel per high cycle.
REQ-010 clear_all  in  1  empties the whole grid.
REQ-011 q_valid  in  1  cell query request.
REQ-012 q_col  in  4  queried column 0..9; q_row  in  5  queried row 0..19.
REQ-013 r_valid  out  1  query response strobe.
REQ-014 r_occupied  out  1  queried cell occupied; r_colour  out  6  queried cell colour.
REQ-015 scan_start  in  1  start full-row scan; scan_busy  out  1  scan in progress.
REQ-016 scan_done  out  1  one-cycle pulse, full_rows valid; full_rows  out  20  bit r set = row r fully occupied.
REQ-017 oob_count  out  8  count of plots that fell outside the board.

Function
REQ-018 Grid SHALL be 10 columns x 20 rows; per cell one occupancy bit and a 6-bit colour.
REQ-019 On plot high, dx=x-ORIGIN_X, dy=y-ORIGIN_Y; in-board iff x>=ORIGIN_X, y>=ORIGIN_Y, dx>>CELL_SHIFT<10, dy>>CELL_SHIFT<20.
REQ-020 In-board plot SHALL update cell (dx>>CELL_SHIFT, dy>>CELL_SHIFT) on that edge: colour!=0 sets occupied and stores colour; colour==0 clears occupied and colour.
REQ-021 Out-of-board plot SHALL leave the grid unchanged and increment oob_count, saturating at 8'd255.
REQ-022 clear_all SHALL clear every cell in one cycle and take priority over a simultaneous plot.
REQ-023 Query: q_valid high at edge N SHALL give r_valid=1 with r_occupied/r_colour at edge N+1; r_valid low otherwise.
REQ-024 Query of out-of-range cell (q_col>9 or q_row>19) SHALL return r_occupied=1, r_colour=0 (walls count as solid).
REQ-025 Query and plot to the same cell in the same cycle SHALL return the pre-write value.
REQ-026 Scan FSM states IDLE, SCAN, DONE; IDLE->SCAN on scan_start; SCAN examines row k at its k-th cycle, k=0..19, then ->DONE; DONE pulses scan_done for one cycle and ->IDLE.
REQ-027 Total scan latency SHALL be 21 cycles from scan_start edge to scan_done pulse; scan_busy high in SCAN and DONE.
REQ-028 scan_start while scan_busy SHALL be ignored.
REQ-029 Plots during SCAN SHALL apply; each row's bit reflects grid contents at the cycle that row is examined.
REQ-030 clear_all during SCAN SHALL not abort the scan; rows examined afterward read empty.
REQ-031 full_rows SHALL hold its last value until the next scan_done.

Reset
REQ-032 resetn low SHALL immediately empty the grid and force r_valid=0, r_occupied=0, r_colour=0, scan_busy=0, scan_done=0, full_rows=0, oob_count=0, FSM=IDLE.
REQ-033 Reset mid-scan SHALL abandon the scan with no scan_done pulse.

Configuration
REQ-034 Macro PLOT_GRID_COLOUR_STORE_EN defined: per-cell colour stored and returned per REQ-020/023.
REQ-035 Macro undefined: colour storage SHALL not be built, r_colour SHALL be constant 6'd0, occupancy behaviour unchanged.

Verification
REQ-036 Reset, plot x=16,y=8,colour=6'h30, query (0,0) -> next cycle r_valid=1, r_occupied=1, r_colour=6'h30.
REQ-037 Plot x=55,y=87,colour=6'h0C, then x=56,y=8 and x=15,y=8 -> cell (9,19) occupied; oob_count=2; query (10,0) -> r_occupied=1.
REQ-038 Fill row 19 (plot one pixel per column 0..9), scan_start -> scan_done exactly 21 cycles later, full_rows=20'h80000.
REQ-039 Start scan, plot colour=0 into row 19 column 3 at cycle 2, second scan_start at cycle 5 -> one scan_done only, full_rows bit 19 = 0.
REQ-040 Plot and query same cell same cycle -> pre-write value; clear_all with simultaneous plot -> all cells empty.
REQ-041 resetn low at scan cycle 10 -> all outputs 0, no scan_done; rebuild without macro -> r_colour always 0.
